pipelined_ripple_adder: RTL and testbench

- Parametrised, pipelined successor to the team's 4-bit combinational ripple-carry adder.
- Splits a DATA_WIDTH addition into DATA_WIDTH/CHUNK_WIDTH ripple chunks, with one chunk per register stage.
- Uses a valid/ready stream handshake on input and output.
- Used in datapaths where a full-width combinational carry chain breaks timing. Sustains one add per cycle.

---
 rtl/pipe_adder_pkg.sv | 27 ++
 rtl/adder_chunk_stage.sv | 97 +++++++++
 rtl/pipelined_ripple_adder.sv | 106 ++++++++++
 tb/tb_pipelined_ripple_adder.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/pipe_adder_pkg.sv
// Shared definitions for the pipelined ripple-carry adder: default widths,
// stage-count derivation, the stage record layout and the full-adder cell.
package pipe_adder_pkg;

  localparam int DEF_DATA_WIDTH  = 16;
  localparam int DEF_CHUNK_WIDTH = 4;

  // Pipeline depth: one register stage per chunk.
  function automatic int stages_of(input int data_width, input int chunk_width);
    return data_width / chunk_width;
  endfunction

  // Stage record at the default width. Non-default widths use the same
  // field order, declared locally where the widths are known.
  typedef struct packed {
    logic                        valid;
    logic [DEF_DATA_WIDTH-1:0]   sum_lo;
    logic                        carry;
    logic [2*DEF_DATA_WIDTH-1:0] ops_hi;
  } stage_rec_t;

  // Full-adder cell, returned as {carry_out, sum}.
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic ci);
    return {(a & b) | (a & ci) | (b & ci), a ^ b ^ ci};
  endfunction

endpackage

// File: rtl/adder_chunk_stage.sv
// One pipeline stage: a CHUNK_WIDTH ripple add on chunk IDX of the operands,
// followed by the stage register (enable = global advance, synchronous clear).
// Operands travel at full width; bits already consumed are never read
// downstream and are trimmed by synthesis.
// Optional: PIPE_ADDER_OVF_EN adds a registered signed-overflow flag.
module adder_chunk_stage
  import pipe_adder_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int CHUNK_WIDTH = DEF_CHUNK_WIDTH,
  parameter int IDX         = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  prev_vld,
  input  logic [DATA_WIDTH-1:0] prev_sum,
  input  logic                  prev_carry,
  input  logic [DATA_WIDTH-1:0] prev_a,
  input  logic [DATA_WIDTH-1:0] prev_b,
  output logic                  vld,
  output logic [DATA_WIDTH-1:0] sum,
  output logic                  carry,
  output logic [DATA_WIDTH-1:0] a,
  output logic [DATA_WIDTH-1:0] b
`ifdef PIPE_ADDER_OVF_EN
  ,
  output logic                  ovf
`endif
);

  localparam int LO = IDX * CHUNK_WIDTH;

  typedef struct packed {
    logic                  valid;
    logic [DATA_WIDTH-1:0] sum;
    logic                  carry;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
  } stage_t;

  stage_t                 stage_reg;
  stage_t                 stage_next;
  logic [CHUNK_WIDTH:0]   c;
  logic [CHUNK_WIDTH-1:0] chunk_sum;

  // Ripple chain through this chunk, one full-adder cell per bit.
  assign c[0] = prev_carry;
  genvar gi;
  generate
    for (gi = 0; gi < CHUNK_WIDTH; gi++) begin : g_bit
      assign {c[gi+1], chunk_sum[gi]} = full_add(prev_a[LO+gi], prev_b[LO+gi], c[gi]);
    end
  endgenerate

  // Insert this chunk into the partial sum; everything else passes through.
  always_comb begin
    stage_next              = '0;
    stage_next.valid        = prev_vld;
    stage_next.sum          = prev_sum;
    stage_next.sum[LO +: CHUNK_WIDTH] = chunk_sum;
    stage_next.carry        = c[CHUNK_WIDTH];
    stage_next.a            = prev_a;
    stage_next.b            = prev_b;
  end

  // Stage register: clears on reset, loads on advance, otherwise holds.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stage_reg <= '0;
    end else if (en) begin
      stage_reg <= stage_next;
    end
  end

  assign vld   = stage_reg.valid;
  assign sum   = stage_reg.sum;
  assign carry = stage_reg.carry;
  assign a     = stage_reg.a;
  assign b     = stage_reg.b;

`ifdef PIPE_ADDER_OVF_EN
  logic ovf_reg;

  // Signed overflow: carry into this chunk's top bit differs from carry out.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_reg <= 1'b0;
    end else if (en) begin
      ovf_reg <= c[CHUNK_WIDTH-1] ^ c[CHUNK_WIDTH];
    end
  end

  assign ovf = ovf_reg;
`endif

endmodule

// File: rtl/pipelined_ripple_adder.sv
// Pipelined ripple-carry adder: DATA_WIDTH add split into STAGES chunks of
// CHUNK_WIDTH bits, one chunk per register stage, valid/ready on both sides.
// The whole pipeline advances together on adv, so bubbles are kept.
// Optional: PIPE_ADDER_OVF_EN adds the out_ovf signed-overflow output.
module pipelined_ripple_adder
  import pipe_adder_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int CHUNK_WIDTH = DEF_CHUNK_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  input  logic                  in_ci,
  input  logic                  in_vld,
  output logic                  in_rd,
  output logic [DATA_WIDTH-1:0] out_s,
  output logic                  out_co,
  output logic                  out_vld,
  input  logic                  out_rd
`ifdef PIPE_ADDER_OVF_EN
  ,
  output logic                  out_ovf
`endif
);

  localparam int STAGES = stages_of(DATA_WIDTH, CHUNK_WIDTH);

  generate
    if (DATA_WIDTH % CHUNK_WIDTH != 0) begin : g_width_check
      $error("DATA_WIDTH must be a multiple of CHUNK_WIDTH");
    end
  endgenerate

  logic                  adv;
  logic                  vld_w   [STAGES];
  logic [DATA_WIDTH-1:0] sum_w   [STAGES];
  logic                  carry_w [STAGES];
  logic [DATA_WIDTH-1:0] a_w     [STAGES];
  logic [DATA_WIDTH-1:0] b_w     [STAGES];
`ifdef PIPE_ADDER_OVF_EN
  logic                  ovf_w   [STAGES];
`endif

  // Move whenever the output slot is empty or being drained.
  assign adv   = out_rd | ~out_vld;
  assign in_rd = adv;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      logic                  p_vld;
      logic [DATA_WIDTH-1:0] p_sum;
      logic                  p_carry;
      logic [DATA_WIDTH-1:0] p_a;
      logic [DATA_WIDTH-1:0] p_b;

      if (gi == 0) begin : g_first
        assign p_vld   = in_vld & adv;
        assign p_sum   = '0;
        assign p_carry = in_ci;
        assign p_a     = in_a;
        assign p_b     = in_b;
      end else begin : g_rest
        assign p_vld   = vld_w[gi-1];
        assign p_sum   = sum_w[gi-1];
        assign p_carry = carry_w[gi-1];
        assign p_a     = a_w[gi-1];
        assign p_b     = b_w[gi-1];
      end

      adder_chunk_stage #(
        .DATA_WIDTH (DATA_WIDTH),
        .CHUNK_WIDTH(CHUNK_WIDTH),
        .IDX        (gi)
      ) u_stage (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (adv),
        .prev_vld  (p_vld),
        .prev_sum  (p_sum),
        .prev_carry(p_carry),
        .prev_a    (p_a),
        .prev_b    (p_b),
        .vld       (vld_w[gi]),
        .sum       (sum_w[gi]),
        .carry     (carry_w[gi]),
        .a         (a_w[gi]),
        .b         (b_w[gi])
`ifdef PIPE_ADDER_OVF_EN
        ,
        .ovf       (ovf_w[gi])
`endif
      );
    end
  endgenerate

  assign out_vld = vld_w[STAGES-1];
  assign out_s   = sum_w[STAGES-1];
  assign out_co  = carry_w[STAGES-1];
`ifdef PIPE_ADDER_OVF_EN
  assign out_ovf = ovf_w[STAGES-1];
`endif

endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// Directed bench for pipelined_ripple_adder at DATA_WIDTH=16, CHUNK_WIDTH=4.
// Covers PIPE_ADDER_OVF_EN when that macro is defined.
module tb_pipelined_ripple_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        in_ci;
  logic        in_vld;
  logic        in_rd;
  logic [15:0] out_s;
  logic        out_co;
  logic        out_vld;
  logic        out_rd;
`ifdef PIPE_ADDER_OVF_EN
  logic        out_ovf;
`endif

  int n_cmp = 0;
  int n_mis = 0;

  pipelined_ripple_adder #(
    .DATA_WIDTH (16),
    .CHUNK_WIDTH(4)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .in_a   (in_a),
    .in_b   (in_b),
    .in_ci  (in_ci),
    .in_vld (in_vld),
    .in_rd  (in_rd),
    .out_s  (out_s),
    .out_co (out_co),
    .out_vld(out_vld),
    .out_rd (out_rd)
`ifdef PIPE_ADDER_OVF_EN
    ,
    .out_ovf(out_ovf)
`endif
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs and checks happen 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
    $display("check %-18s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic ci, input logic v);
    in_a   = a;
    in_b   = b;
    in_ci  = ci;
    in_vld = v;
  endtask

  task automatic chk_beat(input string tag, input logic [15:0] s, input logic co);
    chk({tag, ".vld"}, 32'(out_vld), 32'd1);
    chk({tag, ".s"},   32'(out_s),   32'(s));
    chk({tag, ".co"},  32'(out_co),  32'(co));
  endtask

  initial begin
    rst_n  = 1'b0;
    out_rd = 1'b1;
    drive(16'h0, 16'h0, 1'b0, 1'b0);
    #1;
    tick();
    tick();

    // Reset state.
    chk("rst.vld", 32'(out_vld), 32'd0);
    chk("rst.s",   32'(out_s),   32'd0);
    chk("rst.co",  32'(out_co),  32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst.in_rd", 32'(in_rd), 32'd1);

    // Single beat: 0xFFFF + 0x0001 wraps to 0 with carry, latency 4.
    drive(16'hFFFF, 16'h0001, 1'b0, 1'b1);
    tick();
    drive(16'h0, 16'h0, 1'b0, 1'b0);
    chk("lat.e1", 32'(out_vld), 32'd0);
    tick();
    chk("lat.e2", 32'(out_vld), 32'd0);
    tick();
    chk("lat.e3", 32'(out_vld), 32'd0);
    tick();
    chk_beat("single", 16'h0000, 1'b1);
    tick();
    chk("single.drain", 32'(out_vld), 32'd0);

    // Back-to-back stream of four beats.
    drive(16'h1234, 16'h1111, 1'b0, 1'b1); tick();
    drive(16'h00FF, 16'h0001, 1'b1, 1'b1); tick();
    drive(16'h8000, 16'h8000, 1'b0, 1'b1); tick();
    drive(16'h0000, 16'h0000, 1'b1, 1'b1); tick();
    drive(16'h0, 16'h0, 1'b0, 1'b0);
    chk_beat("strm0", 16'h2345, 1'b0); tick();
    chk_beat("strm1", 16'h0101, 1'b0); tick();
    chk_beat("strm2", 16'h0000, 1'b1); tick();
    chk_beat("strm3", 16'h0001, 1'b0); tick();
    chk("strm.drain", 32'(out_vld), 32'd0);

    // Backpressure: fill, stall 3 cycles with a fifth beat waiting.
    drive(16'h0001, 16'h0002, 1'b0, 1'b1); tick();
    drive(16'hF000, 16'h1000, 1'b0, 1'b1); tick();
    drive(16'h1111, 16'h2222, 1'b1, 1'b1); tick();
    drive(16'hFFFF, 16'hFFFF, 1'b1, 1'b1); tick();
    drive(16'h4000, 16'h0400, 1'b0, 1'b1);
    out_rd = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("bp.in_rd", 32'(in_rd), 32'd0);
      chk_beat("bp.hold", 16'h0003, 1'b0);
      tick();
    end
    chk_beat("bp.hold", 16'h0003, 1'b0);
    out_rd = 1'b1;
    #1;
    chk("bp.rel.in_rd", 32'(in_rd), 32'd1);
    tick();
    drive(16'h0, 16'h0, 1'b0, 1'b0);
    chk_beat("bp1", 16'h0000, 1'b1); tick();
    chk_beat("bp2", 16'h3334, 1'b0); tick();
    chk_beat("bp3", 16'hFFFF, 1'b1); tick();
    chk_beat("bp4", 16'h4400, 1'b0); tick();
    chk("bp.drain", 32'(out_vld), 32'd0);

    // Reset with three beats in flight: nothing may emerge afterwards.
    drive(16'h1357, 16'h2468, 1'b0, 1'b1); tick();
    drive(16'hAAAA, 16'h5555, 1'b0, 1'b1); tick();
    drive(16'h0F0F, 16'h00F0, 1'b1, 1'b1); tick();
    drive(16'h0, 16'h0, 1'b0, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mrst.vld", 32'(out_vld), 32'd0);
    chk("mrst.s",   32'(out_s),   32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("mrst.no_stale", 32'(out_vld), 32'd0);
    end

`ifdef PIPE_ADDER_OVF_EN
    // Signed overflow versus unsigned carry.
    drive(16'h7FFF, 16'h0001, 1'b0, 1'b1); tick();
    drive(16'hFFFF, 16'h0001, 1'b0, 1'b1); tick();
    drive(16'h0, 16'h0, 1'b0, 1'b0);
    tick();
    tick();
    chk_beat("ovf0", 16'h8000, 1'b0);
    chk("ovf0.ovf", 32'(out_ovf), 32'd1);
    tick();
    chk_beat("ovf1", 16'h0000, 1'b1);
    chk("ovf1.ovf", 32'(out_ovf), 32'd0);
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
